// File: rtl/dma_copy_engine.sv
// Word-at-a-time memory-to-memory copy engine with registered bus strobes and a bus-wait timeout.
// Optional fill mode (writes a constant instead of copying) is enabled by defining DMA_FILL_EN.
module dma_copy_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [22:1] src_addr,
    input  logic [22:1] dst_addr,
    input  logic [15:0] word_count,
`ifdef DMA_FILL_EN
    input  logic        fill_mode,
    input  logic [15:0] fill_value,
`endif
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [22:1] bus_address,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_cs,
    output logic        bus_uds,
    output logic        bus_lds,
    output logic        bus_write_strobe,
    input  logic        bus_ack
);

    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE} state_t;

    state_t      state_q, state_d;
    logic [22:1] src_q, dst_q;
    logic [15:0] remaining_q;
    logic [15:0] hold_q;
    logic [7:0]  wait_q;
    logic        error_q;

    logic        active_access;
    logic        timeout;
    logic        fill_now;
    logic [15:0] fill_data;
    logic        cs_d, we_d;
    logic [22:1] addr_d;
    logic [15:0] dout_d;

    assign active_access = (state_q == RD) || (state_q == WR);
    // The 255th consecutive wait cycle is the one where the counter still reads 254.
    assign timeout = active_access && !bus_ack && (wait_q == 8'd254);

`ifdef DMA_FILL_EN
    logic        fill_q;
    logic [15:0] fill_val_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (state_q == IDLE && start) begin
            fill_q     <= fill_mode;
            fill_val_q <= fill_value;
        end
    end

    // In IDLE the transfer being accepted is described by the live inputs.
    assign fill_now  = (state_q == IDLE) ? fill_mode  : fill_q;
    assign fill_data = (state_q == IDLE) ? fill_value : fill_val_q;
`else
    assign fill_now  = 1'b0;
    assign fill_data = 16'h0000;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every variable gets a default at the top of always_comb, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (word_count == 16'd0) ? DONE : (fill_now ? WR : RD);
            RD:      if (bus_ack) state_d = RD_GAP; else if (timeout) state_d = DONE;
            RD_GAP:  state_d = WR;
            WR:      if (bus_ack) state_d = WR_GAP; else if (timeout) state_d = DONE;
            WR_GAP:  state_d = (remaining_q == 16'd1) ? DONE : (fill_now ? WR : RD);
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are precomputed from the next state and registered below.
    always_comb begin
        busy   = (state_q == RD) || (state_q == RD_GAP) || (state_q == WR) || (state_q == WR_GAP);
        done   = (state_q == DONE);
        error  = error_q;
        cs_d   = (state_d == RD) || (state_d == WR);
        we_d   = (state_d == WR);
        addr_d = bus_address;
        dout_d = bus_dout;
        case (state_q)
            IDLE: begin
                if (start && word_count != 16'd0) begin
                    addr_d = fill_now ? dst_addr : src_addr;
                    dout_d = fill_data;
                end
            end
            RD_GAP: begin
                addr_d = dst_q;
                dout_d = hold_q;
            end
            WR_GAP: begin
                addr_d = fill_now ? dst_q + 22'd1 : src_q + 22'd1;
                dout_d = fill_now ? fill_data : bus_dout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q            <= '0;
            dst_q            <= '0;
            remaining_q      <= '0;
            hold_q           <= '0;
            wait_q           <= '0;
            error_q          <= 1'b0;
            bus_cs           <= 1'b0;
            bus_uds          <= 1'b0;
            bus_lds          <= 1'b0;
            bus_write_strobe <= 1'b0;
            bus_address      <= '0;
            bus_dout         <= '0;
        end else begin
            bus_cs           <= cs_d;
            bus_uds          <= cs_d;
            bus_lds          <= cs_d;
            bus_write_strobe <= we_d;
            bus_address      <= addr_d;
            bus_dout         <= dout_d;
            wait_q           <= (active_access && !bus_ack) ? wait_q + 8'd1 : 8'd0;
            if (timeout) error_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q       <= src_addr;
                        dst_q       <= dst_addr;
                        remaining_q <= word_count;
                        error_q     <= 1'b0;
                    end
                end
                RD:     if (bus_ack) hold_q <= bus_din;
                WR_GAP: begin
                    src_q       <= src_q + 22'd1;
                    dst_q       <= dst_q + 22'd1;
                    remaining_q <= remaining_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: a sparse-memory responder with programmable wait states,
// a word-list copy model, directed vector table, random transfers, timeout and reset corner cases.
module tb_dma_copy_engine;

    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [22:1] src_addr, dst_addr;
    logic [15:0] word_count;
    logic        busy, done, error;
    logic [22:1] bus_address;
    logic [15:0] bus_dout, bus_din;
    logic        bus_cs, bus_uds, bus_lds, bus_write_strobe, bus_ack;
`ifdef DMA_FILL_EN
    logic        fill_mode;
    logic [15:0] fill_value;
`endif

    dma_copy_engine dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
`ifdef DMA_FILL_EN
        .fill_mode(fill_mode), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .error(error),
        .bus_address(bus_address), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_cs(bus_cs), .bus_uds(bus_uds), .bus_lds(bus_lds),
        .bus_write_strobe(bus_write_strobe), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic [21:0] src;
        logic [21:0] dst;
        logic [15:0] cnt;
        int          rw;
        int          ww;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int   lat;
        logic busy0, err0, err_done, cs_done, busy_done;
    } res_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem       [logic [21:0]];
    logic [15:0] model_mem [logic [21:0]];
    acc_t        log_q[$];
    int          rd_wait = 0, wr_wait = 0;
    int          acc_cycles = 0, cs_cycles = 0, qual_bad = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] seed_word(input logic [21:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {10'd0, a[21:16]};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [21:0] a);
        if (mem.exists(a)) return mem[a];
        return seed_word(a);
    endfunction

    function automatic logic [15:0] model_rd(input logic [21:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return seed_word(a);
    endfunction

    // Responder: decides ack mid-cycle from the access's elapsed wait, commits the access when acked.
    initial begin
        bus_ack = 1'b0;
        bus_din = '0;
        forever begin
            @(negedge clk);
            if (bus_cs) begin
                cs_cycles++;
                if (acc_cycles >= (bus_write_strobe ? wr_wait : rd_wait)) begin
                    bus_ack = 1'b1;
                    if (bus_write_strobe) begin
                        mem[bus_address] = bus_dout;
                        log_q.push_back(acc_t'{1'b1, bus_address, bus_dout});
                    end else begin
                        bus_din = mem_rd(bus_address);
                        log_q.push_back(acc_t'{1'b0, bus_address, bus_din});
                    end
                    acc_cycles = 0;
                end else begin
                    bus_ack = 1'b0;
                    bus_din = 16'($urandom);
                    acc_cycles++;
                end
            end else begin
                bus_ack    = 1'b0;
                bus_din    = 16'($urandom);
                acc_cycles = 0;
            end
            if (bus_uds !== bus_cs || bus_lds !== bus_cs) qual_bad++;
        end
    end

    task automatic run_xfer(input logic [21:0] s, input logic [21:0] d, input logic [15:0] c,
                            input int rw, input int ww, output res_t r);
        rd_wait   = rw;
        wr_wait   = ww;
        log_q.delete();
        cs_cycles = 0;
        qual_bad  = 0;
        @(negedge clk);
        src_addr   = s;
        dst_addr   = d;
        word_count = c;
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        r.busy0 = busy;
        r.err0  = error;
        r.lat   = 0;
        while (done !== 1'b1 && r.lat < LIMIT) begin
            @(negedge clk);
            r.lat++;
        end
        r.err_done  = error;
        r.cs_done   = bus_cs;
        r.busy_done = busy;
        @(negedge clk);
    endtask

    // Copy model: words move one at a time in ascending order, so overlap propagates naturally.
    task automatic do_copy(input string tag, input vec_t v);
        res_t        r;
        acc_t        exp_q[$];
        logic [21:0] as, ad;
        logic [15:0] val;
        int          mism;
        model_mem = mem;
        for (int i = 0; i < int'(v.cnt); i++) begin
            as  = v.src + 22'(i);
            ad  = v.dst + 22'(i);
            val = model_rd(as);
            model_mem[ad] = val;
            exp_q.push_back(acc_t'{1'b0, as, val});
            exp_q.push_back(acc_t'{1'b1, ad, val});
        end
        run_xfer(v.src, v.dst, v.cnt, v.rw, v.ww, r);
        check({tag, "_latency"}, r.lat, v.exp_lat);
        check({tag, "_busy_first"}, r.busy0, v.cnt != 16'd0);
        check({tag, "_busy_at_done"}, r.busy_done, 1'b0);
        check({tag, "_error"}, r.err_done, 1'b0);
        check({tag, "_cs_at_done"}, r.cs_done, 1'b0);
        check({tag, "_access_count"}, log_q.size(), exp_q.size());
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= log_q.size() || log_q[i] !== exp_q[i]) mism++;
        check({tag, "_access_seq"}, mism, 0);
        for (int i = 0; i < int'(v.cnt); i++) begin
            ad = v.dst + 22'(i);
            check($sformatf("%s_dst%0d", tag, i), mem_rd(ad), model_rd(ad));
        end
        check({tag, "_uds_lds"}, qual_bad, 0);
    endtask

    initial begin
        vec_t        vecs[7];
        vec_t        rv;
        res_t        r;
        logic [21:0] a2;
        int          dones;

        vecs[0] = '{22'h000100, 22'h000200, 16'd3, 0, 0, 12};
        vecs[1] = '{22'h000400, 22'h000500, 16'd2, 1, 0, 10};
        vecs[2] = '{22'h000600, 22'h000700, 16'd0, 0, 0, 0};
        vecs[3] = '{22'h3FFFFF, 22'h000800, 16'd2, 0, 0, 8};
        vecs[4] = '{22'h000900, 22'h3FFFFE, 16'd4, 0, 1, 20};
        vecs[5] = '{22'h000A00, 22'h000A01, 16'd4, 0, 0, 16};
        vecs[6] = '{22'h123456, 22'h234567, 16'd3, 2, 3, 27};

        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; word_count = '0;
`ifdef DMA_FILL_EN
        fill_mode = 1'b0; fill_value = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_strobes", {bus_cs, bus_uds, bus_lds, bus_write_strobe}, 4'b0000);
        check("rst_address", bus_address, 22'h0);
        check("rst_dout", bus_dout, 16'h0);
        reset = 1'b0;

        mem[22'h000100] = 16'h1111;
        mem[22'h000101] = 16'h2222;
        mem[22'h000102] = 16'h3333;

        for (int k = 0; k < 7; k++) begin
            do_copy($sformatf("vec%0d", k), vecs[k]);
            if (k == 0) begin
                check("basic_dst200", mem_rd(22'h000200), 16'h1111);
                check("basic_dst201", mem_rd(22'h000201), 16'h2222);
                check("basic_dst202", mem_rd(22'h000202), 16'h3333);
            end
            if (k == 2) check("cnt0_cs_cycles", cs_cycles, 0);
            if (k == 3) begin
                a2 = (log_q.size() > 2) ? log_q[2].addr : 22'h155555;
                check("wrap_second_read_addr", a2, 22'h000000);
            end
        end

        for (int n = 0; n < 20; n++) begin
            rv.src = ($urandom_range(0, 3) == 0) ? 22'h3FFFFC + 22'($urandom_range(0, 3)) : 22'($urandom);
            rv.dst = ($urandom_range(0, 3) == 0) ? 22'h3FFFFC + 22'($urandom_range(0, 3)) : 22'($urandom);
            rv.cnt = 16'($urandom_range(1, 6));
            rv.rw  = $urandom_range(0, 3);
            rv.ww  = $urandom_range(0, 3);
            rv.exp_lat = int'(rv.cnt) * (4 + rv.rw + rv.ww);
            do_copy($sformatf("rnd%0d", n), rv);
        end

        // Read never acknowledged: abort after 255 wait cycles with error and done together.
        run_xfer(22'h000C00, 22'h000D00, 16'd2, 100000, 0, r);
        check("rd_timeout_latency", r.lat, 255);
        check("rd_timeout_error", r.err_done, 1'b1);
        check("rd_timeout_cs_dropped", r.cs_done, 1'b0);
        check("rd_timeout_no_access", log_q.size(), 0);
        repeat (3) @(negedge clk);
        check("error_held_idle", error, 1'b1);
        run_xfer(22'h000C00, 22'h000D00, 16'd1, 0, 100000, r);
        check("new_start_clears_error", r.err0, 1'b0);
        check("wr_timeout_latency", r.lat, 257);
        check("wr_timeout_error", r.err_done, 1'b1);
        check("wr_timeout_mem_untouched", mem_rd(22'h000D00), seed_word(22'h000D00));
        do_copy("after_timeout", '{22'h000E00, 22'h000F00, 16'd1, 0, 0, 4});

        // Reset while a write is stalled.
        rd_wait = 0;
        wr_wait = 100000;
        @(negedge clk);
        src_addr = 22'h001100; dst_addr = 22'h001200; word_count = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && bus_write_strobe !== 1'b1; n++) @(negedge clk);
        check("rst_mid_reached_wr", bus_write_strobe, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_strobes", {bus_cs, bus_uds, bus_lds, bus_write_strobe}, 4'b0000);
        check("rst_mid_busy", busy, 1'b0);
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        check("rst_mid_no_done", dones, 0);
        check("rst_mid_idle", busy, 1'b0);
        wr_wait = 0;

`ifdef DMA_FILL_EN
        fill_mode  = 1'b1;
        fill_value = 16'hBEEF;
        run_xfer(22'h000000, 22'h001000, 16'd3, 0, 0, r);
        fill_mode  = 1'b0;
        check("fill_latency", r.lat, 6);
        check("fill_access_count", log_q.size(), 3);
        check("fill_w0", mem_rd(22'h001000), 16'hBEEF);
        check("fill_w2", mem_rd(22'h001002), 16'hBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
